// File: rtl/clk_mux_gf_n.sv
`timescale 1ns/1ps
// Glitch-free N-way clock multiplexer. A clk1 control FSM switches sources break-before-make
// through per-source enable chains, with req/ack handshake, done pulse and stuck-clock timeout.
module clk_mux_gf_n #(
  parameter int unsigned NUM_CLK     = 4,
  parameter int unsigned SEL_W       = 2,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TO_CYCLES   = 1024,
  parameter int unsigned RST_SEL     = 0
) (
  input  logic               clk1,
  input  logic               rstn,
  input  logic [NUM_CLK-1:0] clk_in,
  input  logic               sw_req,
  input  logic [SEL_W-1:0]   sw_sel,
  output logic               sw_ack,
  output logic               sw_rej,
  output logic               busy,
  output logic               sw_done,
  output logic [SEL_W-1:0]   cur_sel,
  output logic               sw_timeout,
  input  logic               to_clr,
  output logic [NUM_CLK-1:0] en_status,
  output logic               clk_out
);

  localparam int unsigned        CNT_W   = $clog2(TO_CYCLES + 1);
  localparam logic [NUM_CLK-1:0] RST_OH  = NUM_CLK'(1) << RST_SEL;
  localparam logic [CNT_W-1:0]   TO_MAX  = CNT_W'(TO_CYCLES);
  localparam logic [CNT_W-1:0]   TO_LAST = CNT_W'(TO_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, DROP, WAIT_OFF, RAISE, WAIT_ON, DONE} state_t;

  state_t             state;
  logic [NUM_CLK-1:0] req;
  logic [SEL_W-1:0]   target;
  logic [CNT_W-1:0]   to_cnt;
  logic [NUM_CLK-1:0] gate;
  logic [NUM_CLK-1:0] en_sync [SYNC_STAGES];

  // Switch sequencer: drop old request, wait for all enables off, raise new, wait for it on.
  always_ff @(posedge clk1 or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      req        <= RST_OH;
      target     <= SEL_W'(RST_SEL);
      cur_sel    <= SEL_W'(RST_SEL);
      to_cnt     <= '0;
      sw_ack     <= 1'b0;
      sw_rej     <= 1'b0;
      busy       <= 1'b0;
      sw_done    <= 1'b0;
      sw_timeout <= 1'b0;
    end else begin
      sw_ack  <= 1'b0;
      sw_rej  <= 1'b0;
      sw_done <= 1'b0;
      if (to_clr) sw_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (sw_req) begin
            if (32'(sw_sel) >= NUM_CLK) begin
              sw_rej <= 1'b1;
            end else begin
              sw_ack <= 1'b1;
              busy   <= 1'b1;
              target <= sw_sel;
              state  <= (sw_sel == cur_sel) ? DONE : DROP;
            end
          end
        end
        DROP: begin
          req[cur_sel] <= 1'b0;
          to_cnt       <= '0;
          state        <= WAIT_OFF;
        end
        WAIT_OFF, WAIT_ON: begin
          // Timeout only flags; the wait continues until the clock comes back.
          if (to_cnt != TO_MAX) to_cnt <= to_cnt + 1'b1;
          if (to_cnt >= TO_LAST) sw_timeout <= 1'b1;
          if (state == WAIT_OFF) begin
            if (en_status == '0) state <= RAISE;
          end else if (en_status[target]) begin
            cur_sel <= target;
            state   <= DONE;
          end
        end
        RAISE: begin
          req[target] <= 1'b1;
          to_cnt      <= '0;
          state       <= WAIT_ON;
        end
        DONE: begin
          sw_done <= 1'b1;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Per-source enable chain: sync in the source domain, gate flop on its falling edge.
  for (genvar i = 0; i < int'(NUM_CLK); i++) begin : g_ch
    localparam logic [NUM_CLK-1:0]     OTH_MASK  = ~(NUM_CLK'(1) << i);
    localparam logic [NUM_CLK-1:0]     OTH_RST   = RST_OH & OTH_MASK;
    localparam logic [SYNC_STAGES-1:0] CHAIN_RST = (i == int'(RST_SEL)) ? '1 : '0;
    localparam logic                   GATE_RST  = (i == int'(RST_SEL)) ? 1'b1 : 1'b0;

    logic [NUM_CLK-1:0]     oth_sync [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] chain;
    logic                   gate_q;

    always_ff @(posedge clk_in[i] or negedge rstn) begin
      if (!rstn) begin
        for (int s = 0; s < int'(SYNC_STAGES); s++) oth_sync[s] <= OTH_RST;
        chain <= CHAIN_RST;
      end else begin
        oth_sync[0] <= gate & OTH_MASK;
        for (int s = 1; s < int'(SYNC_STAGES); s++) oth_sync[s] <= oth_sync[s-1];
        chain <= {chain[SYNC_STAGES-2:0], req[i] & ~|oth_sync[SYNC_STAGES-1]};
      end
    end

    // Changing on the falling edge keeps the gate stable across every high phase.
    always_ff @(negedge clk_in[i] or negedge rstn) begin
      if (!rstn) gate_q <= GATE_RST;
      else       gate_q <= chain[SYNC_STAGES-1];
    end

    assign gate[i] = gate_q;
  end

  // Gate enables brought back to clk1 for the FSM and status port.
  always_ff @(posedge clk1 or negedge rstn) begin
    if (!rstn) begin
      for (int s = 0; s < int'(SYNC_STAGES); s++) en_sync[s] <= RST_OH;
    end else begin
      en_sync[0] <= gate;
      for (int s = 1; s < int'(SYNC_STAGES); s++) en_sync[s] <= en_sync[s-1];
    end
  end

  assign en_status = en_sync[SYNC_STAGES-1];
  assign clk_out   = |(clk_in & gate);

endmodule
